// File: rtl/char_input_ctrl.sv
// Player input scheduler: synchronises and debounces the buttons, resolves left/right
// ownership, and issues frame-aligned step/jump commands with a jump cooldown.
module char_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES      = 40000,
  parameter int unsigned JUMP_COOLDOWN_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_jump,
  input  logic frame_start,
  input  logic enable,
  output logic stepleft,
  output logic stepright,
  output logic stepjump,
  output logic facing
);

  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CDW = $clog2(JUMP_COOLDOWN_FRAMES + 1);
  localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CDW-1:0] CD_LOAD = CDW'(JUMP_COOLDOWN_FRAMES);

  typedef enum logic [1:0] {OWN_NONE, OWN_LEFT, OWN_RIGHT} owner_t;
  typedef enum logic [1:0] {J_IDLE, J_FIRE, J_COOLDOWN} jstate_t;

  // Button index: 0 = left, 1 = right, 2 = jump
  logic [2:0]    sync1, sync2, stable, stable_q, rise;
  logic [CW-1:0] cnt [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1    <= {btn_jump, btn_right, btn_left};
      sync2    <= sync1;
      stable_q <= stable;
      // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i]    <= '0;
          stable[i] <= ~stable[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb rise = stable & ~stable_q;

  owner_t owner, owner_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner <= OWN_NONE;
    else     owner <= owner_n;
  end

  always_comb begin
    owner_n = owner;
    if (rise[0])                         owner_n = OWN_LEFT;
    else if (rise[1])                    owner_n = OWN_RIGHT;
    else if (!stable[0] && !stable[1])   owner_n = OWN_NONE;
    else if (owner == OWN_LEFT  && !stable[0]) owner_n = OWN_RIGHT;
    else if (owner == OWN_RIGHT && !stable[1]) owner_n = OWN_LEFT;
  end

  jstate_t        jstate, jstate_n;
  logic           jump_pend, pend_n;
  logic [CDW-1:0] cd_cnt, cd_n;
  logic           sl_n, sr_n, sj_n, facing_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jstate    <= J_IDLE;
      jump_pend <= 1'b0;
      cd_cnt    <= '0;
      stepleft  <= 1'b0;
      stepright <= 1'b0;
      stepjump  <= 1'b0;
      facing    <= 1'b0;
    end else begin
      jstate    <= jstate_n;
      jump_pend <= pend_n;
      cd_cnt    <= cd_n;
      stepleft  <= sl_n;
      stepright <= sr_n;
      stepjump  <= sj_n;
      facing    <= facing_n;
    end
  end

  always_comb begin
    jstate_n = jstate;
    pend_n   = jump_pend;
    cd_n     = cd_cnt;
    sl_n     = stepleft;
    sr_n     = stepright;
    sj_n     = stepjump;
    facing_n = facing;
    if (frame_start) begin
      if (!enable) begin
        jstate_n = J_IDLE;
        pend_n   = 1'b0;
        cd_n     = '0;
        sl_n     = 1'b0;
        sr_n     = 1'b0;
        sj_n     = 1'b0;
      end else begin
        sl_n = (owner == OWN_LEFT);
        sr_n = (owner == OWN_RIGHT);
        if (owner == OWN_LEFT)       facing_n = 1'b1;
        else if (owner == OWN_RIGHT) facing_n = 1'b0;
        case (jstate)
          J_IDLE: begin
            if (jump_pend) begin
              pend_n   = 1'b0;
              sj_n     = 1'b1;
              jstate_n = J_FIRE;
            end
          end
          J_FIRE: begin
            sj_n     = 1'b0;
            cd_n     = CD_LOAD;
            pend_n   = 1'b0;
            jstate_n = J_COOLDOWN;
          end
          J_COOLDOWN: begin
            pend_n = 1'b0;
            cd_n   = cd_cnt - CDW'(1);
            if (cd_cnt == CDW'(1)) jstate_n = J_IDLE;
          end
          default: jstate_n = J_IDLE;
        endcase
      end
    end
    // A press coinciding with frame_start is kept for the following frame
    if (rise[2]) pend_n = 1'b1;
  end

endmodule

// File: tb/tb_char_input_ctrl.sv
// Bench for char_input_ctrl: per-cycle comparison against a behavioural model,
// plus directed scenarios with literal expectations.
module tb_char_input_ctrl;
  localparam int DB    = 4;
  localparam int CD    = 3;
  localparam int FRAME = 100;

  logic clk = 1'b0, rst = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic frame_start = 1'b0, enable = 1'b1;
  logic stepleft, stepright, stepjump, facing;

  int total = 0;
  int bad   = 0;
  int pos   = FRAME - 1;

  always #5 clk = ~clk;

  char_input_ctrl #(.DEBOUNCE_CYCLES(DB), .JUMP_COOLDOWN_FRAMES(CD)) dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .frame_start(frame_start), .enable(enable),
    .stepleft(stepleft), .stepright(stepright), .stepjump(stepjump), .facing(facing)
  );

  initial begin
    forever begin
      @(negedge clk);
      pos = (pos + 1) % FRAME;
      frame_start = (pos == 0);
    end
  end

  // Behavioural model: each raw input is remembered as a sample history; a debounced
  // level flips once DB consecutive samples (seen two cycles late) disagree with it.
  logic [DB+1:0] h [3];
  logic [2:0]    m_lvl = '0, m_lvl_q = '0;
  int            m_owner = 0;  // 0 none, 1 left, 2 right
  int            m_cd = 0;
  logic          m_pend = 1'b0, m_sl = 1'b0, m_sr = 1'b0, m_sj = 1'b0, m_f = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) h[i] = '0;
    m_lvl = '0; m_lvl_q = '0; m_owner = 0; m_cd = 0;
    m_pend = 1'b0; m_sl = 1'b0; m_sr = 1'b0; m_sj = 1'b0; m_f = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0]    raw, rise;
    logic [DB-1:0] win;
    int            own_old;
    raw  = {btn_jump, btn_right, btn_left};
    rise = m_lvl & ~m_lvl_q;
    own_old = m_owner;
    if (rise[0])                            m_owner = 1;
    else if (rise[1])                       m_owner = 2;
    else if (!m_lvl[0] && !m_lvl[1])        m_owner = 0;
    else if (m_owner == 1 && !m_lvl[0])     m_owner = 2;
    else if (m_owner == 2 && !m_lvl[1])     m_owner = 1;
    if (frame_start) begin
      if (!enable) begin
        m_sl = 1'b0; m_sr = 1'b0; m_sj = 1'b0; m_cd = 0; m_pend = 1'b0;
      end else begin
        m_sl = (own_old == 1);
        m_sr = (own_old == 2);
        if (own_old == 1)      m_f = 1'b1;
        else if (own_old == 2) m_f = 1'b0;
        if (m_sj) begin
          m_sj = 1'b0; m_cd = CD; m_pend = 1'b0;
        end else if (m_cd > 0) begin
          m_cd = m_cd - 1; m_pend = 1'b0;
        end else if (m_pend) begin
          m_pend = 1'b0; m_sj = 1'b1;
        end
      end
    end
    if (rise[2]) m_pend = 1'b1;
    m_lvl_q = m_lvl;
    for (int i = 0; i < 3; i++) begin
      h[i] = {h[i][DB:0], raw[i]};
      win  = h[i][DB+1:2];
      if (win == (m_lvl[i] ? {DB{1'b0}} : {DB{1'b1}})) m_lvl[i] = ~m_lvl[i];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      total++;
      if ({stepleft, stepright, stepjump, facing} !== {m_sl, m_sr, m_sj, m_f}) begin
        bad++;
        $display("FAIL model_cmp t=%0t got l/r/j/f=%b%b%b%b want %b%b%b%b", $time,
                 stepleft, stepright, stepjump, facing, m_sl, m_sr, m_sj, m_f);
      end
    end
  end

  task automatic chk(string nm, logic got, logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  task automatic chk_out(string nm, logic l, logic r, logic j, logic f);
    chk({nm, ".stepleft"},  stepleft,  l);
    chk({nm, ".stepright"}, stepright, r);
    chk({nm, ".stepjump"},  stepjump,  j);
    chk({nm, ".facing"},    facing,    f);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(int n);
    repeat (n) step();
  endtask

  task automatic wait_pos(int p);
    do step(); while (pos != p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int jumps;
    #1 rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    chk_out("reset", 0, 0, 0, 0);

    wait_pos(50); btn_right = 1'b1; cycles(20);
    wait_pos(50); chk_out("right_hold", 0, 1, 0, 0);

    cycles(10); rst = 1'b1; step();
    chk_out("rst_mid", 0, 0, 0, 0);
    cycles(2); rst = 1'b0;
    wait_pos(50); chk_out("after_rst", 0, 1, 0, 0);

    btn_left = 1'b1; cycles(3); btn_left = 1'b0;
    wait_pos(50); chk_out("glitch", 0, 1, 0, 0);

    btn_left = 1'b1;
    wait_pos(50); chk_out("left_over_right", 1, 0, 0, 1);
    btn_left = 1'b0;
    wait_pos(50); chk_out("left_release", 0, 1, 0, 0);
    btn_right = 1'b0;
    wait_pos(50); chk_out("none_held", 0, 0, 0, 0);
    btn_left = 1'b1; btn_right = 1'b1;
    wait_pos(50); chk_out("both_rise", 1, 0, 0, 1);
    btn_left = 1'b0; btn_right = 1'b0;
    wait_pos(50); chk_out("facing_held", 0, 0, 0, 1);

    btn_jump = 1'b1; cycles(10); btn_jump = 1'b0;
    wait_pos(50); chk("jump_n1", stepjump, 1'b1);
    for (int f = 2; f <= 5; f++) begin
      wait_pos(50); chk($sformatf("jump_n%0d", f), stepjump, 1'b0);
      btn_jump = 1'b1; cycles(10); btn_jump = 1'b0;
    end
    wait_pos(50); chk("jump_n6", stepjump, 1'b1);
    wait_pos(50); chk("jump_n7", stepjump, 1'b0);

    repeat (4) wait_pos(50);
    btn_jump = 1'b1;
    jumps = 0;
    repeat (10) begin
      wait_pos(50);
      if (stepjump) jumps++;
    end
    btn_jump = 1'b0;
    total++;
    if (jumps != 1) begin
      bad++;
      $display("FAIL held_jump: got %0d jump frames want 1", jumps);
    end

    wait_pos(94); btn_jump = 1'b1;
    wait_pos(50); chk("simul_same_frame", stepjump, 1'b0);
    wait_pos(50); chk("simul_next_frame", stepjump, 1'b1);
    btn_jump = 1'b0;

    repeat (4) wait_pos(50);
    btn_right = 1'b1; btn_jump = 1'b1; cycles(10); btn_jump = 1'b0;
    wait_pos(50); chk_out("pre_disable_fire", 0, 1, 1, 0);
    wait_pos(50); enable = 1'b0;
    wait_pos(50); chk_out("disabled", 0, 0, 0, 0);
    btn_left = 1'b1;
    wait_pos(50); chk_out("disabled_left", 0, 0, 0, 0);
    enable = 1'b1; btn_jump = 1'b1; cycles(10); btn_jump = 1'b0;
    wait_pos(50); chk_out("reenable", 1, 0, 1, 1);
    enable = 1'b0;
    wait_pos(50); chk_out("disable_facing_held", 0, 0, 0, 1);

    btn_left = 1'b0; btn_right = 1'b0; enable = 1'b1;
    repeat (2) wait_pos(50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
